// File: rtl/sweep_ctrl_pkg.sv
// Shared definitions for the sweep sequencer: state encoding and default widths.
// The optional stall counter is enabled by defining SWEEP_CTRL_STALL_CNT_EN.
package sweep_ctrl_pkg;

    localparam int DEF_BITS_OF_END_NUMBER = 20;
    localparam int DEF_PASS_BITS          = 8;
    localparam int DEF_STALL_BITS         = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sweep_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Instantiated by sweep_ctrl only when SWEEP_CTRL_STALL_CNT_EN is defined.
module sweep_ctrl_sat_cnt
    import sweep_ctrl_pkg::*;
#(
    parameter int W = DEF_STALL_BITS
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next value: clear, or increment unless already all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep sequencer driving an external wrap-around enable counter.
// Runs P passes of length L per accepted start, stalls on ready_in=0,
// and ends each job with a one-cycle done pulse.
// Handshake: cnt_en is high exactly when the FSM is in RUN and ready_in is
// high; a counter step and any wrap happen only on those cycles.
// Optional: define SWEEP_CTRL_STALL_CNT_EN to add the stall_cycles output.
module sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int BITS_OF_END_NUMBER = DEF_BITS_OF_END_NUMBER,
    parameter int PASS_BITS          = DEF_PASS_BITS
`ifdef SWEEP_CTRL_STALL_CNT_EN
    ,
    parameter int STALL_BITS         = DEF_STALL_BITS
`endif
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [BITS_OF_END_NUMBER-1:0] cfg_len,
    input  logic [PASS_BITS-1:0]          cfg_passes,
    input  logic                          ready_in,
    input  logic [BITS_OF_END_NUMBER-1:0] cnt_q,
    output logic                          cnt_en,
    output logic [BITS_OF_END_NUMBER-1:0] cnt_final,
    output logic                          cnt_clr,
    output logic [PASS_BITS-1:0]          pass_idx,
    output logic                          busy,
    output logic                          done
`ifdef SWEEP_CTRL_STALL_CNT_EN
    ,
    output logic [STALL_BITS-1:0]         stall_cycles
`endif
);

    localparam logic [BITS_OF_END_NUMBER-1:0] LEN_ONE  = {{(BITS_OF_END_NUMBER-1){1'b0}}, 1'b1};
    localparam logic [PASS_BITS-1:0]          PASS_ONE = {{(PASS_BITS-1){1'b0}}, 1'b1};

    state_e                        state_q, state_d;
    logic [BITS_OF_END_NUMBER-1:0] final_q, final_d;
    logic [PASS_BITS-1:0]          limit_q, limit_d;
    logic [PASS_BITS-1:0]          idx_q, idx_d;
    logic                          clr_q;
    logic                          done_q;
    logic                          busy_q;

    logic start_acc;
    logic in_run;
    logic wrap;
    logic last_pass;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign in_run    = (state_q == ST_RUN);
    // Combinational so a stall removes the enable in the same cycle.
    assign cnt_en    = in_run && ready_in;
    // final_q >= 1 whenever RUN is reachable, so final_q-1 never underflows there.
    assign wrap      = cnt_en && (cnt_q == (final_q - LEN_ONE));
    assign last_pass = (idx_q == (limit_q - PASS_ONE));

    // Next-state and datapath decode.
    always_comb begin
        state_d = state_q;
        final_d = final_q;
        limit_d = limit_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    final_d = cfg_len;
                    limit_d = cfg_passes;
                    idx_d   = '0;
                    if ((cfg_len == '0) || (cfg_passes == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (wrap) begin
                    if (last_pass) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + PASS_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched job config, and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            final_q <= '0;
            limit_q <= '0;
            idx_q   <= '0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            final_q <= final_d;
            limit_q <= limit_d;
            idx_q   <= idx_d;
            clr_q   <= (state_d == ST_CLEAR);
            done_q  <= (state_d == ST_DONE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign cnt_final = final_q;
    assign cnt_clr   = clr_q;
    assign pass_idx  = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef SWEEP_CTRL_STALL_CNT_EN
    sweep_ctrl_sat_cnt #(
        .W (STALL_BITS)
    ) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .clr_i  (start_acc),
        .inc_i  (in_run && !ready_in),
        .cnt_o  (stall_cycles)
    );
`else
    // start_acc only feeds the stall counter.
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed self-checking bench for sweep_ctrl. A simple wrap-around enable
// counter model sits beside the DUT and feeds cnt_q back, as in the system.
module tb_sweep_ctrl;

    localparam int B  = 20;
    localparam int PB = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [B-1:0]  cfg_len = '0;
    logic [PB-1:0] cfg_passes = '0;
    logic          ready_in = 1'b0;
    logic [B-1:0]  cnt_q;
    logic          cnt_en;
    logic [B-1:0]  cnt_final;
    logic          cnt_clr;
    logic [PB-1:0] pass_idx;
    logic          busy;
    logic          done;
`ifdef SWEEP_CTRL_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    // Environment counter with an override used for wide boundary values.
    logic [B-1:0]  ctr_q;
    logic          ovr_en = 1'b0;
    logic [B-1:0]  ovr_val = '0;

    int n_checks = 0;
    int n_pass   = 0;

    sweep_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .cfg_len    (cfg_len),
        .cfg_passes (cfg_passes),
        .ready_in   (ready_in),
        .cnt_q      (cnt_q),
        .cnt_en     (cnt_en),
        .cnt_final  (cnt_final),
        .cnt_clr    (cnt_clr),
        .pass_idx   (pass_idx),
        .busy       (busy),
        .done       (done)
`ifdef SWEEP_CTRL_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctr_q <= '0;
        end else if (cnt_clr) begin
            ctr_q <= '0;
        end else if (cnt_en) begin
            ctr_q <= (ctr_q == cnt_final - 1) ? '0 : ctr_q + 1'b1;
        end
    end
    assign cnt_q = ovr_en ? ovr_val : ctr_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One job: start now, stall window [s_at, s_at+s_len) in cycles after start,
    // optional ignored start (with different cfg) at cycle redo_at.
    task automatic run_job(input int l, input int p, input int s_at, input int s_len,
                           input int redo_at, input string tag);
        int e;
        int k;
        bit degen;
        degen = (l == 0) || (p == 0);
        cfg_len    = B'(l);
        cfg_passes = PB'(p);
        start      = 1'b1;
        ready_in   = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check({tag, " t1 clr"},   32'(cnt_clr), degen ? 32'd0 : 32'd1);
        check({tag, " t1 done"},  32'(done),    degen ? 32'd1 : 32'd0);
        check({tag, " t1 en"},    32'(cnt_en),  32'd0);
        check({tag, " t1 busy"},  32'(busy),    32'd1);
        check({tag, " t1 final"}, 32'(cnt_final), 32'(l));
        check({tag, " t1 idx"},   32'(pass_idx), 32'd0);
`ifdef SWEEP_CTRL_STALL_CNT_EN
        check({tag, " stall clr"}, 32'(stall_cycles), 32'd0);
`endif
        if (!degen) begin
            e = 0;
            k = 2;
            while (e < l * p) begin
                next_cycle();
                ready_in = !((k >= s_at) && (k < s_at + s_len));
                start    = (k == redo_at);
                if (k == redo_at) begin
                    cfg_len    = B'(l + 3);
                    cfg_passes = PB'(p + 2);
                end
                @(negedge clk);
                check($sformatf("%s k%0d en", tag, k),    32'(cnt_en),   32'(ready_in));
                check($sformatf("%s k%0d idx", tag, k),   32'(pass_idx), 32'(e / l));
                check($sformatf("%s k%0d done", tag, k),  32'(done),     32'd0);
                check($sformatf("%s k%0d clr", tag, k),   32'(cnt_clr),  32'd0);
                check($sformatf("%s k%0d final", tag, k), 32'(cnt_final), 32'(l));
                if (ready_in) e++;
                k++;
            end
            next_cycle();
            start    = 1'b0;
            ready_in = 1'b1;
            @(negedge clk);
            check({tag, " done pulse"}, 32'(done),     32'd1);
            check({tag, " done en"},    32'(cnt_en),   32'd0);
            check({tag, " done busy"},  32'(busy),     32'd1);
            check({tag, " done idx"},   32'(pass_idx), 32'(p - 1));
        end
        next_cycle();
        @(negedge clk);
        check({tag, " end done"}, 32'(done),    32'd0);
        check({tag, " end busy"}, 32'(busy),    32'd0);
        check({tag, " end clr"},  32'(cnt_clr), 32'd0);
        check({tag, " end idx"},  32'(pass_idx), degen ? 32'd0 : 32'(p - 1));
`ifdef SWEEP_CTRL_STALL_CNT_EN
        check({tag, " stall cnt"}, 32'(stall_cycles), degen ? 32'd0 : 32'(s_len));
`endif
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        #1;
        check("rst en",    32'(cnt_en),    32'd0);
        check("rst clr",   32'(cnt_clr),   32'd0);
        check("rst done",  32'(done),      32'd0);
        check("rst busy",  32'(busy),      32'd0);
        check("rst idx",   32'(pass_idx),  32'd0);
        check("rst final", 32'(cnt_final), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        next_cycle();

        run_job(4, 2, 0, 0, 0, "l4p2");
        run_job(3, 1, 3, 2, 0, "l3p1stall");
        run_job(0, 5, 0, 0, 0, "len0");
        run_job(6, 0, 0, 0, 0, "pass0");
        run_job(1, 3, 0, 0, 0, "l1p3");
        run_job(4, 2, 0, 0, 4, "restart");
        run_job(2, 3, 4, 3, 0, "l2p3stall");

        // Async reset mid-RUN.
        next_cycle();
        cfg_len    = 20'd5;
        cfg_passes = 8'd2;
        start      = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (3) next_cycle();
        #1;
        check("mid run en", 32'(cnt_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst en",    32'(cnt_en),    32'd0);
        check("arst busy",  32'(busy),      32'd0);
        check("arst clr",   32'(cnt_clr),   32'd0);
        check("arst done",  32'(done),      32'd0);
        check("arst idx",   32'(pass_idx),  32'd0);
        check("arst final", 32'(cnt_final), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post rst done", 32'(done), 32'd0);
            check("post rst busy", 32'(busy), 32'd0);
        end
        run_job(2, 1, 0, 0, 0, "after rst");

        // Maximum L and P: full-width wrap compare via cnt_q override.
        cfg_len    = 20'hFFFFF;
        cfg_passes = 8'hFF;
        start      = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        ovr_en  = 1'b1;
        ovr_val = 20'h7FFFE;
        @(negedge clk);
        check("max en",    32'(cnt_en),    32'd1);
        check("max final", 32'(cnt_final), 32'hFFFFF);
        next_cycle();
        ovr_val = 20'hFFFFE;
        @(negedge clk);
        check("max no wrap", 32'(pass_idx), 32'd0);
        next_cycle();
        ovr_val = 20'hFFFFF;
        @(negedge clk);
        check("max wrap", 32'(pass_idx), 32'd1);
        check("max busy", 32'(busy),     32'd1);
        next_cycle();
        @(negedge clk);
        check("max hold idx", 32'(pass_idx), 32'd1);
        check("max no done",  32'(done),     32'd0);
        reset_n = 1'b0;
        ovr_en  = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
